jt51_pg_sched: RTL and testbench
================================

JT51_PG_SCHED -- requirements
Module: jt51_pg_sched

Interface
REQ-001 SHALL have parameter SLOTS, default 32, the number of operator slots per frame; only 32 is supported.
REQ-002 SHALL have port clk  input  1  the single system clock.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port cen  input  1  clock enable; all state advances only on clk edges with cen=1.
REQ-005 SHALL have port kon_we  input  1  key-on write strobe from the register interface.
REQ-006 SHALL have port kon_ch  input  3  channel index of the write.
REQ-007 SHALL have port kon_sl  input  4  operator key mask: bit0 M1, bit1 M2, bit2 C1, bit3 C2.
REQ-008 SHALL have port kon_ready  output  1  high when a key-on write can be accepted.
REQ-009 SHALL have port zero  output  1  high during the cen cycle in which slot_I=0.
REQ-010 SHALL have port slot_I  output  5  slot presented to phase-generator stage I.
REQ-011 SHALL have port pg_rst_III  output  1  phase reset for the slot in stage III.
REQ-012 SHALL have port keyon_III  output  1  key-on state of the slot in stage III.

Function
REQ-013 SHALL advance slot_I by 1 modulo 32 on every clk edge with cen=1; 31 wraps to 0.
REQ-014 SHALL map the channel ch operators to slots ch (M1), ch+8 (M2), ch+16 (C1) and ch+24 (C2).
REQ-015 SHALL capture {kon_ch, kon_sl} into a pending register on the edge where kon_we=1 and kon_ready=1, regardless of cen.
REQ-016 SHALL drive kon_ready low from the edge after capture until the edge after the commit.
REQ-017 SHALL ignore kon_we while kon_ready=0 and SHALL NOT alter the pending register.
REQ-018 SHALL commit the pending request on the cen edge where slot_I changes from 31 to 0 (the frame boundary).
REQ-019 SHALL on commit write the four mask bits into the 32-bit key-on state for that channel's slots and leave all other slots unchanged.
REQ-020 SHALL on commit replace the 32-bit rise mask with the bits of slots that go from 0 to 1; slots that stay on, turn off or are untouched SHALL be 0.
REQ-021 SHALL clear the rise mask at a frame boundary that has no pending request, so each rising edge produces exactly one pg_rst per slot.
REQ-022 SHALL accept a capture on the same edge as a commit only if kon_ready was already high, so one request is outstanding at a time.
REQ-023 SHALL form stage-I values rise[slot_I] and kon[slot_I], with the kon value taken after any commit on that edge.
REQ-024 SHALL delay both stage-I values by exactly 2 cen edges to give pg_rst_III and keyon_III, aligned to the phase-generator stage III.
REQ-025 SHALL hold all outputs and state when cen=0, except the capture allowed by REQ-015.
REQ-026 SHALL perform no arithmetic beyond the 5-bit slot wrap; slot indices SHALL be formed by concatenating op and ch, never by wider addition.

Reset
REQ-027 SHALL on rst=1 set slot_I=0, the key-on state to 0, the rise mask to 0, the pending register to empty and the delay stages to 0.
REQ-028 SHALL therefore output after reset: kon_ready=1, zero=1, pg_rst_III=0, keyon_III=0.
REQ-029 SHALL give rst priority over cen and kon_we, and SHALL discard a pending request if reset arrives mid-frame.

Structure
REQ-030 SHALL take the constants SLOTS=32 and the operator slot offsets (M1=0, M2=8, C1=16, C2=24) from the shared package jt51_pkg.
REQ-031 SHALL build the 2-stage delay from one instance of the existing shift-register sub-module jt51_sh (width 2, stages 2); no other sub-module is used.

Verification
REQ-032 SHALL cover reset with cen=1 held for 32 edges -> slot_I runs 0..31 then 0, zero is high once per 32 edges, pg_rst_III=0 throughout.
REQ-033 SHALL cover a write ch=3, sl=4'b1111 at slot 10 -> kon_ready=0 until the boundary; in the next frame pg_rst_III=1 and keyon_III=1 two cen edges after slot_I=3, 11, 19 and 27, and pg_rst_III=0 in the frame after.
REQ-034 SHALL cover a second write ch=3, sl=4'b0011 after the first -> slots 3 and 11 give keyon_III=1 with pg_rst_III=0; slots 19 and 27 give keyon_III=0.
REQ-035 SHALL cover two kon_we pulses in one frame (ch=1 then ch=2) -> only ch=1 is committed and ch=2 is dropped; the bench SHALL report the drop.
REQ-036 SHALL cover cen toggling every other clock -> slot and output timing scale with cen only, and a capture while cen=0 is still accepted.
REQ-037 SHALL cover rst asserted at slot 20 with a request pending -> all state is cleared and the request never produces pg_rst_III.

Source files
------------

// File: rtl/jt51_pkg.sv
// rtl/jt51_pkg.sv - shared constants and types for the jt51 operator slot logic
package jt51_pkg;

    localparam int SLOTS = 32;

    // Each operator owns an 8-slot bank; the bank number is slot[4:3].
    localparam logic [4:0] SLOT_M1 = 5'd0;
    localparam logic [4:0] SLOT_M2 = 5'd8;
    localparam logic [4:0] SLOT_C1 = 5'd16;
    localparam logic [4:0] SLOT_C2 = 5'd24;

    localparam logic [4:0] SLOT_BASE [4] = '{SLOT_M1, SLOT_M2, SLOT_C1, SLOT_C2};

    typedef struct packed {
        logic       valid;
        logic [2:0] ch;
        logic [3:0] sl;
    } kon_req_t;

endpackage

// File: rtl/jt51_sh.sv
// rtl/jt51_sh.sv - clock-enabled shift register, width bits by stages deep
module jt51_sh #(
    parameter int width  = 2,
    parameter int stages = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic [width-1:0] din,
    output logic [width-1:0] drop
);

    logic [width-1:0] bits [stages];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < stages; i++) bits[i] <= '0;
        end else if (cen) begin
            bits[0] <= din;
            for (int i = 1; i < stages; i++) bits[i] <= bits[i-1];
        end
    end

    assign drop = bits[stages-1];

endmodule

// File: rtl/jt51_pg_sched.sv
// rtl/jt51_pg_sched.sv - key-on scheduler producing per-slot phase reset for the PG pipeline
module jt51_pg_sched
    import jt51_pkg::*;
#(
    parameter int SLOTS = jt51_pkg::SLOTS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       kon_we,
    input  logic [2:0] kon_ch,
    input  logic [3:0] kon_sl,
    output logic       kon_ready,
    output logic       zero,
    output logic [4:0] slot_I,
    output logic       pg_rst_III,
    output logic       keyon_III
);

    logic [SLOTS-1:0] kon;
    logic [SLOTS-1:0] rise;
    logic [SLOTS-1:0] kon_next;
    kon_req_t         pend;
    logic             frame_end;

    assign frame_end = cen && (slot_I == 5'd31);
    assign kon_ready = ~pend.valid;
    assign zero      = (slot_I == 5'd0);

    // Slot index is {operator bank, channel}: no adders involved.
    always_comb begin
        kon_next = kon;
        for (int op = 0; op < 4; op++) begin
            kon_next[{SLOT_BASE[op][4:3], pend.ch}] = pend.sl[op];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_I <= 5'd0;
            kon    <= '0;
            rise   <= '0;
            pend   <= '0;
        end else begin
            if (cen) slot_I <= slot_I + 5'd1;
            if (frame_end) begin
                if (pend.valid) begin
                    kon        <= kon_next;
                    rise       <= kon_next & ~kon;
                    pend.valid <= 1'b0;
                end else begin
                    rise <= '0;
                end
            end
            // Capture ignores cen; a commit on this edge does not reopen the slot.
            if (kon_we && !pend.valid) begin
                pend.valid <= 1'b1;
                pend.ch    <= kon_ch;
                pend.sl    <= kon_sl;
            end
        end
    end

    jt51_sh #(
        .width (2),
        .stages(2)
    ) u_delay (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .din ({rise[slot_I], kon[slot_I]}),
        .drop({pg_rst_III, keyon_III})
    );

endmodule

// File: tb/tb_jt51_pg_sched.sv
// tb/tb_jt51_pg_sched.sv - randomized self-checking bench for jt51_pg_sched
module tb_jt51_pg_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       cen;
    logic       kon_we;
    logic [2:0] kon_ch;
    logic [3:0] kon_sl;
    logic       kon_ready;
    logic       zero;
    logic [4:0] slot_I;
    logic       pg_rst_III;
    logic       keyon_III;

    jt51_pg_sched #(.SLOTS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .kon_we    (kon_we),
        .kon_ch    (kon_ch),
        .kon_sl    (kon_sl),
        .kon_ready (kon_ready),
        .zero      (zero),
        .slot_I    (slot_I),
        .pg_rst_III(pg_rst_III),
        .keyon_III (keyon_III)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: frame-level view of key-on state
    int        m_slot;
    bit [31:0] m_kon;
    bit [31:0] m_rise;
    bit        m_pend;
    bit [2:0]  m_pch;
    bit [3:0]  m_psl;
    bit [1:0]  pipe[$];

    task automatic tick(input bit r, input bit c, input bit we, input bit [2:0] ch, input bit [3:0] sl);
        rst = r; cen = c; kon_we = we; kon_ch = ch; kon_sl = sl;
        @(posedge clk);
        if (r) begin
            m_slot = 0; m_kon = '0; m_rise = '0; m_pend = 0;
            pipe.delete(); pipe.push_back(2'b00); pipe.push_back(2'b00);
        end else begin
            bit cap;
            cap = we && !m_pend;
            if (c) begin
                pipe.push_back({m_rise[m_slot], m_kon[m_slot]});
                void'(pipe.pop_front());
                if (m_slot == 31) begin
                    if (m_pend) begin
                        bit [31:0] nk;
                        nk = m_kon;
                        for (int op = 0; op < 4; op++) nk[m_pch + 8 * op] = m_psl[op];
                        m_rise = nk & ~m_kon;
                        m_kon  = nk;
                        m_pend = 0;
                    end else begin
                        m_rise = '0;
                    end
                end
                m_slot = (m_slot + 1) % 32;
            end
            if (cap) begin
                m_pend = 1; m_pch = ch; m_psl = sl;
            end
        end
        #1;
    endtask

    function automatic logic [8:0] exp_vec();
        return {5'(m_slot), m_slot == 0, !m_pend, pipe[0]};
    endfunction

    task automatic run_to(input int s);
        for (int i = 0; i < 40 && m_slot != s; i++) tick(0, 1, 0, 0, 0);
    endtask

    task automatic test_reset();
        tick(1, 1, 1, 3'd2, 4'hF);
        tick(1, 0, 0, 0, 0);
        if ({slot_I, zero, kon_ready, pg_rst_III, keyon_III} !== 9'b00000_1_1_0_0) begin
            n_bad++; $display("FAIL reset_state: got %b expected %b", {slot_I, zero, kon_ready, pg_rst_III, keyon_III}, 9'b00000_1_1_0_0);
        end
        n_cmp++;
    endtask

    task automatic test_frame_run();
        int zeros = 0, pgs = 0;
        for (int i = 0; i < 32; i++) begin
            tick(0, 1, 0, 0, 0);
            zeros += zero; pgs += pg_rst_III;
            if (slot_I !== 5'((i + 1) % 32)) begin
                n_bad++; $display("FAIL frame_slot: got %0d expected %0d", slot_I, (i + 1) % 32);
            end
            n_cmp++;
        end
        if (zeros !== 1) begin n_bad++; $display("FAIL frame_zero_count: got %0d expected 1", zeros); end
        n_cmp++;
        if (pgs !== 0) begin n_bad++; $display("FAIL frame_pg_idle: got %0d expected 0", pgs); end
        n_cmp++;
    endtask

    task automatic test_full_keyon();
        int pgs = 0;
        run_to(10);
        tick(0, 1, 1, 3'd3, 4'b1111);
        if (kon_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_low: got %b expected 0", kon_ready); end
        n_cmp++;
        for (int i = 0; i < 70; i++) begin
            tick(0, 1, 0, 0, 0);
            pgs += pg_rst_III;
            if ({slot_I, zero, kon_ready, pg_rst_III, keyon_III} !== exp_vec()) begin
                n_bad++; $display("FAIL full_keyon: got %h expected %h", {slot_I, zero, kon_ready, pg_rst_III, keyon_III}, exp_vec());
            end
            n_cmp++;
        end
        if (pgs !== 4) begin n_bad++; $display("FAIL full_pg_count: got %0d expected 4", pgs); end
        n_cmp++;
    endtask

    task automatic test_partial();
        int pgs = 0, kons = 0;
        run_to(10);
        tick(0, 1, 1, 3'd3, 4'b0011);
        for (int i = 0; i < 64; i++) begin
            tick(0, 1, 0, 0, 0);
            pgs += pg_rst_III;
            if (i >= 32) kons += keyon_III;
            if ({slot_I, zero, kon_ready, pg_rst_III, keyon_III} !== exp_vec()) begin
                n_bad++; $display("FAIL partial: got %h expected %h", {slot_I, zero, kon_ready, pg_rst_III, keyon_III}, exp_vec());
            end
            n_cmp++;
        end
        if (pgs !== 0) begin n_bad++; $display("FAIL partial_pg_count: got %0d expected 0", pgs); end
        n_cmp++;
        if (kons !== 2) begin n_bad++; $display("FAIL partial_keyon_count: got %0d expected 2", kons); end
        n_cmp++;
    endtask

    task automatic test_double_write();
        int pgs = 0;
        run_to(5);
        tick(0, 1, 1, 3'd1, 4'b1111);
        tick(0, 1, 0, 0, 0);
        if (kon_ready !== 1'b0) begin n_bad++; $display("FAIL double_ready: got %b expected 0", kon_ready); end
        n_cmp++;
        $display("note: second key-on write (ch=2) issued while kon_ready=0 and is dropped");
        tick(0, 1, 1, 3'd2, 4'b1111);
        for (int i = 0; i < 64; i++) begin
            tick(0, 1, 0, 0, 0);
            pgs += pg_rst_III;
            if ({slot_I, zero, kon_ready, pg_rst_III, keyon_III} !== exp_vec()) begin
                n_bad++; $display("FAIL double_write: got %h expected %h", {slot_I, zero, kon_ready, pg_rst_III, keyon_III}, exp_vec());
            end
            n_cmp++;
        end
        if (pgs !== 4) begin n_bad++; $display("FAIL double_pg_count: got %0d expected 4", pgs); end
        n_cmp++;
    endtask

    task automatic test_cen_toggle();
        for (int i = 0; i < 140; i++) begin
            if (i == 11) tick(0, 0, 1, 3'd5, 4'b0101);
            else         tick(0, (i % 2) == 0, 0, 0, 0);
            if (i == 11 && kon_ready !== 1'b0) begin
                n_bad++; $display("FAIL cen0_capture: got %b expected 0", kon_ready);
            end
            if (i == 11) n_cmp++;
            if ({slot_I, zero, kon_ready, pg_rst_III, keyon_III} !== exp_vec()) begin
                n_bad++; $display("FAIL cen_toggle: got %h expected %h", {slot_I, zero, kon_ready, pg_rst_III, keyon_III}, exp_vec());
            end
            n_cmp++;
        end
    endtask

    task automatic test_reset_pending();
        int pgs = 0;
        run_to(12);
        tick(0, 1, 1, 3'd6, 4'b1111);
        run_to(20);
        tick(1, 1, 0, 0, 0);
        if ({slot_I, zero, kon_ready, pg_rst_III, keyon_III} !== 9'b00000_1_1_0_0) begin
            n_bad++; $display("FAIL reset_pending: got %b expected %b", {slot_I, zero, kon_ready, pg_rst_III, keyon_III}, 9'b00000_1_1_0_0);
        end
        n_cmp++;
        for (int i = 0; i < 70; i++) begin
            tick(0, 1, 0, 0, 0);
            pgs += pg_rst_III;
        end
        if (pgs !== 0) begin n_bad++; $display("FAIL reset_pending_pg: got %0d expected 0", pgs); end
        n_cmp++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            tick($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            if ({slot_I, zero, kon_ready, pg_rst_III, keyon_III} !== exp_vec()) begin
                n_bad++; $display("FAIL random: got %h expected %h", {slot_I, zero, kon_ready, pg_rst_III, keyon_III}, exp_vec());
            end
            n_cmp++;
        end
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; kon_we = 1'b0; kon_ch = '0; kon_sl = '0;
        test_reset();
        test_frame_run();
        test_full_keyon();
        test_partial();
        test_double_write();
        test_cen_toggle();
        test_reset_pending();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
